// File: rtl/cpu_dbg_ctrl.sv
`timescale 1ns/1ps
// cpu_dbg_ctrl: CPU-side debug responder.
// Turns the debug unit's cont level and raw step button into a run enable
// that only stops on instruction boundaries, counts retired instructions,
// and serves debug reads of data RAM / register file over a four-phase
// req/ack handshake that hides the RAM's one-cycle read latency.
module cpu_dbg_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cont,
    input  logic              step,
    input  logic              instr_done,
    output logic              run,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_cnt,
    input  logic              rd_req,
    input  logic              rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [4:0]        reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata
);

    typedef enum logic [1:0] {
        RS_HALT  = 2'd0,
        RS_STEP  = 2'd1,
        RS_RUN   = 2'd2,
        RS_DRAIN = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2,
        RD_ACK  = 2'd3
    } rd_state_t;

    // Step path: two synchronizer stages, one history stage for edge detect.
    logic       step_s1_q, step_s1_d;
    logic       step_s2_q, step_s2_d;
    logic       step_s3_q, step_s3_d;
    // Tracks that the synchronizer holds real post-reset samples; the cleared
    // reset zeros must not count as "button released" for arming.
    logic [1:0] sync_vld_q, sync_vld_d;
    logic       arm_q, arm_d;
    logic       step_pulse_q, step_pulse_d;

    run_state_t       run_state_q, run_state_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    rd_state_t         rd_state_q, rd_state_d;
    logic              rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_ack_q, rd_ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Synchronize step, arm once it is seen released, and detect rising edges.
    always_comb begin
        step_s1_d    = step;
        step_s2_d    = step_s1_q;
        step_s3_d    = step_s2_q;
        sync_vld_d   = {sync_vld_q[0], 1'b1};
        arm_d        = arm_q | (sync_vld_q[1] & ~step_s2_q);
        step_pulse_d = arm_q & step_s2_q & ~step_s3_q;
    end

    // Run FSM next state, registered run enable and retirement counter.
    always_comb begin
        run_state_d = run_state_q;
        instr_cnt_d = instr_cnt_q;
        case (run_state_q)
            RS_HALT: begin
                if (cont)
                    run_state_d = RS_RUN;
                else if (step_pulse_q)
                    run_state_d = RS_STEP;
            end
            RS_STEP: begin
                if (instr_done)
                    run_state_d = RS_HALT;
            end
            RS_RUN: begin
                if (!cont)
                    run_state_d = instr_done ? RS_HALT : RS_DRAIN;
            end
            RS_DRAIN: begin
                if (instr_done)
                    run_state_d = RS_HALT;
            end
            default: run_state_d = RS_HALT;
        endcase
        run_d = (run_state_d != RS_HALT);
        if (instr_done && run_q)
            instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Read FSM: latch request, wait out RAM latency, capture, hold until req drops.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_addr_d  = rd_addr_q;
        rd_ack_d   = rd_ack_q;
        rd_data_d  = rd_data_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_req) begin
                    rd_sel_d   = rd_sel;
                    rd_addr_d  = rd_addr;
                    rd_state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rd_state_d = RD_CAP;
            end
            RD_CAP: begin
                rd_data_d  = rd_sel_q ? mem_rdata : reg_rdata;
                rd_ack_d   = 1'b1;
                rd_state_d = RD_ACK;
            end
            RD_ACK: begin
                if (!rd_req) begin
                    rd_ack_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_s1_q    <= 1'b0;
            step_s2_q    <= 1'b0;
            step_s3_q    <= 1'b0;
            sync_vld_q   <= 2'b00;
            arm_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            run_state_q  <= RS_HALT;
            run_q        <= 1'b0;
            instr_cnt_q  <= '0;
            rd_state_q   <= RD_IDLE;
            rd_sel_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_ack_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            step_s1_q    <= step_s1_d;
            step_s2_q    <= step_s2_d;
            step_s3_q    <= step_s3_d;
            sync_vld_q   <= sync_vld_d;
            arm_q        <= arm_d;
            step_pulse_q <= step_pulse_d;
            run_state_q  <= run_state_d;
            run_q        <= run_d;
            instr_cnt_q  <= instr_cnt_d;
            rd_state_q   <= rd_state_d;
            rd_sel_q     <= rd_sel_d;
            rd_addr_q    <= rd_addr_d;
            rd_ack_q     <= rd_ack_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign run       = run_q;
    assign halted    = (run_state_q == RS_HALT);
    assign instr_cnt = instr_cnt_q;
    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign mem_raddr = rd_addr_q;
    assign reg_raddr = rd_addr_q[4:0];

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
`timescale 1ns/1ps
// tb_cpu_dbg_ctrl: directed scenarios plus a randomized phase, all checked
// every cycle against a behavioural model of run control and debug reads.
module tb_cpu_dbg_ctrl;

    logic        clk;
    logic        rst;
    logic        cont;
    logic        step;
    logic        instr_done;
    logic        run;
    logic        halted;
    logic [15:0] instr_cnt;
    logic        rd_req;
    logic        rd_sel;
    logic [7:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_arr [256];

    cpu_dbg_ctrl #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cont       (cont),
        .step       (step),
        .instr_done (instr_done),
        .run        (run),
        .halted     (halted),
        .instr_cnt  (instr_cnt),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .reg_raddr  (reg_raddr),
        .reg_rdata  (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] regf(input logic [4:0] a);
        return 32'h1357_0000 + ({27'd0, a} * 32'h0001_0203);
    endfunction

    // Synchronous data RAM and combinational register file.
    always @(posedge clk) mem_rdata <= mem_arr[mem_raddr];
    assign reg_rdata = regf(reg_raddr);

    // ---------------- behavioural reference model ----------------
    logic        m_h1, m_h2, m_h3;     // step samples at the last three edges
    int          m_edges;              // edges since reset, saturating at 2
    logic        m_arm, m_pulse;
    logic        m_run, m_single, m_stop;
    logic [15:0] m_cnt;
    int          m_rph;                // edges since a read was latched (0 = none)
    logic        m_sel;
    logic [7:0]  m_addr;
    logic        m_ack;
    logic [31:0] m_data;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_h1 <= 0; m_h2 <= 0; m_h3 <= 0; m_edges <= 0;
            m_arm <= 0; m_pulse <= 0;
            m_run <= 0; m_single <= 0; m_stop <= 0; m_cnt <= 0;
            m_rph <= 0; m_sel <= 0; m_addr <= 0; m_ack <= 0; m_data <= 0;
        end else begin
            m_h1 <= step; m_h2 <= m_h1; m_h3 <= m_h2;
            if (m_edges < 2) m_edges <= m_edges + 1;
            if (m_edges >= 2 && !m_h2) m_arm <= 1;
            m_pulse <= m_arm && m_h2 && !m_h3;
            if (instr_done && m_run) m_cnt <= m_cnt + 16'd1;
            if (!m_run) begin
                if (cont) begin
                    m_run <= 1; m_single <= 0; m_stop <= 0;
                end else if (m_pulse) begin
                    m_run <= 1; m_single <= 1; m_stop <= 0;
                end
            end else if (m_single || m_stop) begin
                if (instr_done) m_run <= 0;
            end else if (!cont) begin
                if (instr_done) m_run <= 0;
                else            m_stop <= 1;
            end
            if (m_rph == 0) begin
                if (rd_req) begin
                    m_sel <= rd_sel; m_addr <= rd_addr; m_rph <= 1;
                end
            end else if (m_rph == 1) begin
                m_rph <= 2;
            end else if (m_rph == 2) begin
                m_data <= m_sel ? mem_arr[m_addr] : regf(m_addr[4:0]);
                m_ack  <= 1;
                m_rph  <= 3;
            end else if (!rd_req) begin
                m_ack <= 0;
                m_rph <= 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("run",       {31'd0, run},       {31'd0, m_run});
        chk("halted",    {31'd0, halted},    {31'd0, ~m_run});
        chk("instr_cnt", {16'd0, instr_cnt}, {16'd0, m_cnt});
        chk("rd_ack",    {31'd0, rd_ack},    {31'd0, m_ack});
        chk("rd_data",   rd_data,            m_data);
        chk("mem_raddr", {24'd0, mem_raddr}, {24'd0, m_addr});
        chk("reg_raddr", {27'd0, reg_raddr}, {27'd0, m_addr[4:0]});
    endtask

    // One clock: outputs sampled 1ns after the edge, then the caller drives.
    task automatic tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_run"},       {31'd0, run},       32'd0);
        chk({pfx, "_halted"},    {31'd0, halted},    32'd1);
        chk({pfx, "_instr_cnt"}, {16'd0, instr_cnt}, 32'd0);
        chk({pfx, "_rd_ack"},    {31'd0, rd_ack},    32'd0);
        chk({pfx, "_rd_data"},   rd_data,            32'd0);
        chk({pfx, "_mem_raddr"}, {24'd0, mem_raddr}, 32'd0);
        chk({pfx, "_reg_raddr"}, {27'd0, reg_raddr}, 32'd0);
    endtask

    // Asynchronous reset asserted mid-cycle, held two edges, released.
    task automatic mid_reset(input string pfx);
        #2 rst = 1'b0;
        #1 check_reset_values(pfx);
        tick();
        tick();
        rst = 1'b1;
    endtask

    int hc;
    int rm;
    int to;
    int hold;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        mem_arr[5] = 32'hDEAD_BEEF;
        rst = 1'b1; cont = 0; step = 1; instr_done = 0;
        rd_req = 0; rd_sel = 0; rd_addr = 0;
        #1 rst = 1'b0;
        #2 check_reset_values("por");

        // Step held through reset must never produce a step.
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("held_step_run",    {31'd0, run},    32'd0);
            chk("held_step_halted", {31'd0, halted}, 32'd1);
        end
        step = 0;
        for (int i = 0; i < 4; i++) tick();

        // Single step: done 4 cycles after run rises -> run high 5 cycles.
        step = 1;
        for (int i = 0; i < 10 && !run; i++) tick();
        chk("step_run_rise", {31'd0, run}, 32'd1);
        hc = 0;
        for (int i = 0; i < 12; i++) begin
            if (run) hc++;
            instr_done = (i == 4);
            tick();
        end
        instr_done = 0;
        chk("step_run_cycles", hc, 32'd5);
        chk("step_cnt",        {16'd0, instr_cnt}, 32'd1);
        chk("step_halted",     {31'd0, halted},    32'd1);
        step = 0;
        tick(); tick();

        // Drop cont mid-instruction, re-raise during drain, HALT still reached.
        cont = 1; tick();
        chk("cont_run", {31'd0, run}, 32'd1);
        tick(); tick();
        cont = 0; tick(); tick();
        chk("drain_run", {31'd0, run}, 32'd1);
        cont = 1; tick(); tick();
        chk("drain_cont_run", {31'd0, run}, 32'd1);
        instr_done = 1; tick();
        instr_done = 0; cont = 0;
        chk("drain_halt_run",    {31'd0, run},       32'd0);
        chk("drain_halt_halted", {31'd0, halted},    32'd1);
        chk("drain_cnt",         {16'd0, instr_cnt}, 32'd2);
        tick(); tick();

        // Memory read of 0x05 with an address change during WAIT.
        rd_sel = 1; rd_addr = 8'h05; rd_req = 1; tick();
        rd_addr = 8'h77; rd_sel = 0; tick();
        chk("mem_ack_early", {31'd0, rd_ack}, 32'd0);
        tick();
        chk("mem_ack",  {31'd0, rd_ack}, 32'd1);
        chk("mem_data", rd_data,         32'hDEAD_BEEF);
        rd_req = 0; tick();
        chk("mem_ack_drop", {31'd0, rd_ack}, 32'd0);
        $display("read sel=1 addr=05 data=%h", rd_data);
        tick();

        // Register read of 0x23, held six extra cycles.
        rd_sel = 0; rd_addr = 8'h23; rd_req = 1; tick();
        chk("reg_raddr_latch", {27'd0, reg_raddr}, 32'd3);
        tick(); tick();
        chk("reg_ack",  {31'd0, rd_ack}, 32'd1);
        chk("reg_data", rd_data,         regf(5'd3));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("reg_ack_hold", {31'd0, rd_ack}, 32'd1);
        end
        rd_req = 0; tick();
        chk("reg_ack_drop", {31'd0, rd_ack}, 32'd0);
        $display("read sel=0 addr=23 data=%h", rd_data);
        tick();

        // Randomized phase: run control and reads concurrently.
        rm = 0; to = 0; hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 23) == 0) cont = ~cont;
            if ($urandom_range(0, 9) == 0)  step = ~step;
            instr_done = ($urandom_range(0, 3) == 0);
            case (rm)
                0: if ($urandom_range(0, 3) == 0) begin
                       rd_sel = $urandom_range(0, 1); rd_addr = 8'($urandom);
                       rd_req = 1; rm = 1; to = 0;
                   end
                1: begin
                       if (rd_ack) begin
                           $display("read sel=%0d addr=%h data=%h", m_sel, m_addr, rd_data);
                           hold = $urandom_range(0, 4); rm = 2;
                       end else if (++to > 10) begin
                           chk("ack_wait", {31'd0, rd_ack}, 32'd1);
                           rd_req = 0; rm = 3; to = 0;
                       end
                       rd_sel = $urandom_range(0, 1); rd_addr = 8'($urandom);
                   end
                2: if (hold == 0) begin rd_req = 0; rm = 3; to = 0; end
                   else hold--;
                default: if (!rd_ack) rm = 0;
                         else if (++to > 10) begin
                             chk("ack_release", {31'd0, rd_ack}, 32'd0);
                             rm = 0;
                         end
            endcase
            tick();
        end
        rd_req = 0; cont = 0; step = 0; instr_done = 1;
        for (int i = 0; i < 6; i++) tick();
        instr_done = 0;

        // Counter wrap: 65535 retirements reach 0xFFFF, one more wraps to 0.
        mid_reset("wrap_rst");
        cont = 1; instr_done = 1;
        for (int i = 0; i < 65536; i++) tick();
        chk("cnt_ffff", {16'd0, instr_cnt}, 32'h0000_FFFF);
        tick();
        chk("cnt_wrap", {16'd0, instr_cnt}, 32'd0);
        cont = 0; instr_done = 0;
        tick(); tick();

        // Reset asserted during ACK aborts the read immediately.
        rd_sel = 1; rd_addr = 8'h05; rd_req = 1;
        tick(); tick(); tick();
        chk("ack_before_rst", {31'd0, rd_ack}, 32'd1);
        rd_req = 0;
        mid_reset("ack_rst");
        for (int i = 0; i < 4; i++) tick();
        chk("ack_after_rst", {31'd0, rd_ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
